// File: rtl/chip_select_sequencer.sv
// Chip-model selector: boots from EEPROM config (or a timeout default), then follows a
// debounced video-standard switch, holding the video core and CPU in reset around every change.
module chip_select_sequencer #(
    parameter logic [1:0]  DEFAULT_CHIP    = 2'b00,
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1000000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd4096,
    parameter logic [23:0] BOOT_TIMEOUT    = 24'd8388607
) (
    input  logic       clk_dot4x,
    input  logic       reset,
    input  logic       standard_sw,
    input  logic [1:0] cfg_chip,
    input  logic       cfg_valid,
    output logic [1:0] chip,
    output logic       rst,
    output logic       cpu_reset,
    output logic       chip_changed
);

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StHold = 2'b01,
        StRun  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d, cnt_inc;
    logic [23:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]  chip_q, chip_d;
    logic        sw_meta_q, sw_sync_q;
    logic        sw_stable_q, sw_stable_d;
    logic        pending_q, pending_d, pending_next;
    logic        load_q, load_d;
    logic        rst_q, rst_d;
    logic        cpu_reset_q;
    logic        chip_changed_q;
    logic        sw_edge;

    always_ff @(posedge clk_dot4x) begin
        if (reset) begin
            state_q        <= StBoot;
            cnt_q          <= '0;
            deb_cnt_q      <= '0;
            chip_q         <= DEFAULT_CHIP;
            sw_meta_q      <= 1'b0;
            sw_sync_q      <= 1'b0;
            sw_stable_q    <= 1'b0;
            pending_q      <= 1'b0;
            load_q         <= 1'b0;
            rst_q          <= 1'b1;
            cpu_reset_q    <= 1'b1;
            chip_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            deb_cnt_q      <= deb_cnt_d;
            chip_q         <= chip_d;
            sw_meta_q      <= standard_sw;
            sw_sync_q      <= sw_meta_q;
            sw_stable_q    <= sw_stable_d;
            pending_q      <= pending_d;
            load_q         <= load_d;
            rst_q          <= rst_d;
            cpu_reset_q    <= rst_d;
            chip_changed_q <= load_q;
        end
    end

    always_comb begin
        // Debouncer: edge fires on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
        sw_edge     = 1'b0;
        deb_cnt_d   = deb_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_sync_q == sw_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEBOUNCE_CYCLES - 24'd1) begin
            deb_cnt_d   = '0;
            sw_stable_d = sw_sync_q;
            sw_edge     = 1'b1;
        end else if (deb_cnt_q != '1) begin
            deb_cnt_d = deb_cnt_q + 24'd1;
        end

        state_d      = state_q;
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
        cnt_d        = cnt_inc;
        chip_d       = chip_q;
        pending_d    = pending_q;
        pending_next = pending_q ^ sw_edge;
        load_d       = 1'b0;

        unique case (state_q)
            StBoot: begin
                if (cfg_valid) begin
                    chip_d = cfg_chip;
                    load_d = 1'b1;
                end else if (cnt_q == BOOT_TIMEOUT - 24'd1) begin
                    chip_d = DEFAULT_CHIP;
                    load_d = 1'b1;
                end
                // Adopt the power-up switch position so it never counts as a toggle.
                if (load_d) begin
                    state_d     = StHold;
                    cnt_d       = '0;
                    sw_stable_d = sw_sync_q;
                    deb_cnt_d   = '0;
                end
            end
            StHold: begin
                pending_d = pending_next;
                if (cnt_q == HOLD_CYCLES - 24'd1) begin
                    cnt_d = '0;
                    if (pending_next) begin
                        pending_d = 1'b0;
                        chip_d    = {chip_q[1], ~chip_q[0]};
                        load_d    = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cnt_d = '0;
                if (cfg_valid && (cfg_chip != chip_q)) begin
                    chip_d  = cfg_chip;
                    load_d  = 1'b1;
                    state_d = StHold;
                end else if (sw_edge) begin
                    chip_d  = {chip_q[1], ~chip_q[0]};
                    load_d  = 1'b1;
                    state_d = StHold;
                end
            end
            default: begin
                state_d = StBoot;
                cnt_d   = '0;
            end
        endcase

        // Outputs trail the state register by one cycle.
        rst_d = (state_q != StRun);
    end

    assign chip         = chip_q;
    assign rst          = rst_q;
    assign cpu_reset    = cpu_reset_q;
    assign chip_changed = chip_changed_q;

endmodule

// File: doc/chip_select_sequencer.md
CHIP_SELECT_SEQUENCER -- requirements
Module: chip_select_sequencer

Interface
REQ-001 SHALL have parameter DEFAULT_CHIP, default 2'b00: chip model used when no configuration arrives (00 NTSC 6567R8, 01 PAL 6569, 10 NTSC 6567R56A, 11 PAL-N 6572; bit 0 = 1 selects PAL colour clock).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 24'd1000000: consecutive stable cycles needed to accept a standard_sw level change.
REQ-003 SHALL have parameter HOLD_CYCLES, default 24'd4096: length of the reset hold after any chip load or change.
REQ-004 SHALL have parameter BOOT_TIMEOUT, default 24'd8388607: cycles to wait for cfg_valid before falling back to DEFAULT_CHIP.
REQ-005 SHALL have port clk_dot4x, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port standard_sw, input, 1: asynchronous video standard toggle switch.
REQ-008 SHALL have port cfg_chip, input, 2: chip model read from EEPROM.
REQ-009 SHALL have port cfg_valid, input, 1: single-cycle strobe qualifying cfg_chip.
REQ-010 SHALL have port chip, output, 2: selected chip model, registered.
REQ-011 SHALL have port rst, output, 1: active-high core reset to the video core.
REQ-012 SHALL have port cpu_reset, output, 1: active-high hold of the 6510 reset.
REQ-013 SHALL have port chip_changed, output, 1: one-cycle pulse on every chip update.

Function
REQ-014 SHALL synchronise standard_sw through two flip-flops before any use.
REQ-015 SHALL debounce as follows: the counter clears whenever the synchronised level equals sw_stable and increments otherwise; when it reaches DEBOUNCE_CYCLES-1, sw_stable takes the synchronised level and one edge event is produced.
REQ-016 SHALL implement states BOOT, HOLD and RUN, encoded in 2 bits.
REQ-017 BOOT SHALL go to HOLD when cfg_valid is high, loading chip from cfg_chip.
REQ-018 BOOT SHALL go to HOLD with chip = DEFAULT_CHIP when the boot counter reaches BOOT_TIMEOUT-1 without cfg_valid.
REQ-019 On BOOT exit, sw_stable SHALL be loaded with the synchronised switch level, and edge events during BOOT SHALL be discarded, so the switch position at power-up never toggles chip.
REQ-020 HOLD SHALL count from 0 and go to RUN on the cycle the counter equals HOLD_CYCLES-1.
REQ-021 rst and cpu_reset SHALL be 1 in BOOT and HOLD and 0 in RUN, as registered outputs that change in the cycle after the state change.
REQ-022 In RUN, a debounced edge event SHALL invert chip[0], leave chip[1] unchanged, and enter HOLD with the counter at 0.
REQ-023 In RUN, cfg_valid with cfg_chip != chip SHALL load cfg_chip and enter HOLD; cfg_valid with cfg_chip == chip SHALL be ignored.
REQ-024 When a cfg_valid load and a switch edge occur in the same RUN cycle, the cfg_valid load SHALL win and the edge SHALL be discarded.
REQ-025 An edge event during HOLD SHALL toggle a pending flag; a second edge SHALL cancel the first; cfg_valid during HOLD SHALL be ignored.
REQ-026 On HOLD to RUN with the pending flag set, the block SHALL clear the flag, invert chip[0] and re-enter HOLD directly, without spending a cycle in RUN, with rst held continuously high.
REQ-027 chip_changed SHALL pulse high for exactly one cycle, the cycle after chip takes a new value, including the BOOT load, even if that value equals DEFAULT_CHIP.
REQ-028 chip SHALL change only on a transition into HOLD, so the downstream clock-mux select stays constant throughout RUN.
REQ-029 All counters SHALL be 24 bits, saturate rather than wrap, and clear on every state entry.

Reset
REQ-030 While reset is high, the block SHALL set state=BOOT, chip=DEFAULT_CHIP, rst=1, cpu_reset=1, chip_changed=0, all counters=0, pending=0 and sw_stable=0.
REQ-031 Reset asserted in any state, including mid-HOLD, SHALL abort the operation and restart from BOOT at the next clock; a cfg_valid arriving in the same cycle as reset SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, BOOT_TIMEOUT=20)
REQ-032 cfg_valid with cfg_chip=01 on cycle 3 after reset -> chip=01 with a chip_changed pulse, then rst=1 for 8 cycles, then rst=0 and cpu_reset=0.
REQ-033 No cfg_valid -> timeout at cycle 20 -> chip=00 with a chip_changed pulse, then rst released after 8 HOLD cycles.
REQ-034 In RUN, standard_sw 0->1 with 2-cycle glitches, then stable -> no toggle during the glitches; after sync plus 4 stable cycles chip goes 01->00 with one chip_changed pulse and rst=1 for 8 cycles.
REQ-035 One switch edge during HOLD -> chip toggles once on HOLD exit and rst stays continuously high; two edges during HOLD -> chip unchanged and rst releases after 8 cycles.
REQ-036 In RUN, cfg_valid with cfg_chip=11 and a debounced edge in the same cycle -> chip=11 exactly, one pulse, edge discarded.
REQ-037 Reset asserted at HOLD count 5 -> next cycle state=BOOT, chip=00, rst=1 and cpu_reset=1, with no chip_changed pulse.
